// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder / register file:
// command word fields, status address, FSM state type, saturating increment.
package spi_cmd_pkg;

    localparam int CMD_WR_BIT = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;

    localparam logic [6:0]  STATUS_ADDR    = 7'h7F;
    localparam logic [15:0] BAD_RD_VAL_DEF = 16'hDEAD;

    typedef enum logic {
        IDLE,
        WAIT_DATA
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_cmd_timeout.sv
// Cycle counter bounding the wait for a write data word.
// Ports: clk, rst_n, clr (restart count), en (count this cycle), expire (last allowed cycle).
module spi_cmd_timeout #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Asserted during the TIMEOUT_CYC-th waiting cycle; a word arriving
    // in that same cycle is still accepted by the decoder.
    assign expire = en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/spi_cmd_regfile.sv
// SPI command decoder and control register file (read / two-word write).
// Ports: clk, rst_n, cs_n_i, rxd_flag_p, rxd_data in; txd_data, reg_q,
// wr_strobe, wr_addr, err_cnt out. Optional macro STATUS_REG_EN maps a
// read-only status word at address 7'h7F.
module spi_cmd_regfile
    import spi_cmd_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [15:0] BAD_RD_VAL  = BAD_RD_VAL_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cs_n_i,
    input  logic                    rxd_flag_p,
    input  logic [15:0]             rxd_data,
    output logic [15:0]             txd_data,
    output logic [16*NUM_REGS-1:0]  reg_q,
    output logic                    wr_strobe,
    output logic [6:0]              wr_addr,
    output logic [7:0]              err_cnt
);

    state_t      state;
    logic [15:0] regs [NUM_REGS];
    logic [6:0]  lat_addr;
    logic        cs_q;
    logic        cs_rise;
    logic        expire;
    logic        cmd_wr;
    logic [6:0]  cmd_addr;
    logic        cmd_ok;
    logic        lat_ok;
    logic        rd_err;
    logic [15:0] rd_val;

    assign cmd_wr   = rxd_data[CMD_WR_BIT];
    assign cmd_addr = rxd_data[ADDR_MSB:ADDR_LSB];
    assign cmd_ok   = int'(cmd_addr) < NUM_REGS;
    assign lat_ok   = int'(lat_addr) < NUM_REGS;
    assign cs_rise  = cs_n_i && !cs_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_q
        assign reg_q[16*k +: 16] = regs[k];
    end

`ifdef STATUS_REG_EN
    logic busy;
    assign busy = (state == WAIT_DATA);
`endif

    always_comb begin
        rd_val = BAD_RD_VAL;
        rd_err = !cmd_ok;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (cmd_addr == 7'(k)) rd_val = regs[k];
        end
`ifdef STATUS_REG_EN
        if (cmd_addr == STATUS_ADDR) begin
            rd_val = {err_cnt, 7'd0, busy};
            rd_err = 1'b0;
        end
`endif
    end

    spi_cmd_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == IDLE && rxd_flag_p && cmd_wr),
        .en     (state == WAIT_DATA),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            txd_data  <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            err_cnt   <= '0;
            lat_addr  <= '0;
            cs_q      <= 1'b1;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            cs_q      <= cs_n_i;
            unique case (state)
                IDLE: begin
                    if (rxd_flag_p) begin
                        if (cmd_wr) begin
                            lat_addr <= cmd_addr;
                            state    <= WAIT_DATA;
                        end else begin
                            txd_data <= rd_val;
                            if (rd_err) err_cnt <= sat_inc(err_cnt);
                        end
                    end
                end
                WAIT_DATA: begin
                    // A data word wins over a same-cycle expiry or CS abort.
                    if (rxd_flag_p) begin
                        txd_data <= rxd_data;
                        state    <= IDLE;
                        if (lat_ok) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= lat_addr;
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (lat_addr == 7'(k)) regs[k] <= rxd_data;
                            end
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end else if (expire || cs_rise) begin
                        state   <= IDLE;
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Self-checking bench for spi_cmd_regfile: directed scenarios plus
// randomized word streams compared against a transaction-level model.
module tb_spi_cmd_regfile;

    localparam int NR = 8;
    localparam int TO = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cs_n_i = 1'b0;
    logic              rxd_flag_p = 1'b0;
    logic [15:0]       rxd_data = '0;
    logic [15:0]       txd_data;
    logic [16*NR-1:0]  reg_q;
    logic              wr_strobe;
    logic [6:0]        wr_addr;
    logic [7:0]        err_cnt;

    int checks = 0;
    int failures = 0;

    // Transaction-level model
    logic [15:0] m_reg [NR];
    logic [15:0] m_txd;
    int          m_err;
    bit          m_pend;
    int          m_paddr;
    bit          m_strb;
    int          m_waddr;

    spi_cmd_regfile #(
        .NUM_REGS(NR),
        .TIMEOUT_CYC(TO),
        .BAD_RD_VAL(16'hDEAD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cs_n_i(cs_n_i),
        .rxd_flag_p(rxd_flag_p),
        .rxd_data(rxd_data),
        .txd_data(txd_data),
        .reg_q(reg_q),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        for (int k = 0; k < NR; k++) m_reg[k] = '0;
        m_txd = '0; m_err = 0; m_pend = 0; m_paddr = 0;
        m_strb = 0; m_waddr = 0;
    endtask

    task automatic m_errinc();
        if (m_err < 255) m_err++;
    endtask

    task automatic m_abort();
        m_strb = 0;
        if (m_pend) begin
            m_pend = 0;
            m_errinc();
        end
    endtask

    task automatic m_word(input logic [15:0] w);
        int a;
        m_strb = 0;
        a = int'(w[14:8]);
        if (m_pend) begin
            m_pend = 0;
            m_txd = w;
            if (m_paddr < NR) begin
                m_reg[m_paddr] = w;
                m_strb = 1;
                m_waddr = m_paddr;
            end else m_errinc();
        end else if (w[15]) begin
            m_pend = 1;
            m_paddr = a;
        end else if (a < NR) begin
            m_txd = m_reg[a];
`ifdef STATUS_REG_EN
        end else if (a == 127) begin
            m_txd = {8'(m_err), 8'h00};
`endif
        end else begin
            m_txd = 16'hDEAD;
            m_errinc();
        end
    endtask

    function automatic logic [16*NR-1:0] m_q();
        logic [16*NR-1:0] e;
        for (int k = 0; k < NR; k++) e[16*k +: 16] = m_reg[k];
        return e;
    endfunction

    // Called at a negedge; returns at the next negedge, outputs updated.
    task automatic drive(input logic [15:0] w);
        rxd_flag_p = 1'b1;
        rxd_data = w;
        @(negedge clk);
        rxd_flag_p = 1'b0;
        m_word(w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        m_reset();
        rst_n = 1'b0;
        idle(2);
        checks++;
        if (txd_data !== 16'h0 || err_cnt !== 8'h0 || wr_strobe !== 1'b0 ||
            wr_addr !== 7'h0 || reg_q !== '0) begin
            failures++;
            $display("FAIL reset txd=%h err=%h strb=%b waddr=%h q=%h",
                     txd_data, err_cnt, wr_strobe, wr_addr, reg_q);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write_read();
        drive(16'h8200);
        checks++;
        if (wr_strobe !== 1'b0) begin
            failures++; $display("FAIL wcmd_strobe got=%b exp=0", wr_strobe);
        end
        drive(16'h1234);
        checks++;
        if (wr_strobe !== 1'b1 || wr_addr !== 7'd2) begin
            failures++;
            $display("FAIL wr_strobe got=%b/%0d exp=1/2", wr_strobe, wr_addr);
        end
        checks++;
        if (reg_q[47:32] !== 16'h1234 || txd_data !== 16'h1234) begin
            failures++;
            $display("FAIL wr_data q=%h txd=%h exp=1234", reg_q[47:32], txd_data);
        end
        idle(1);
        checks++;
        if (wr_strobe !== 1'b0) begin
            failures++; $display("FAIL strobe_len got=%b exp=0", wr_strobe);
        end
        drive(16'h0000);
        drive(16'h0200);
        checks++;
        if (txd_data !== 16'h1234 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rd2 txd=%h err=%0d exp=1234/0", txd_data, err_cnt);
        end
    endtask

    task automatic test_unmapped();
        drive(16'h0A00);
        checks++;
        if (txd_data !== 16'hDEAD || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL unm_rd txd=%h err=%0d exp=dead/1", txd_data, err_cnt);
        end
        drive(16'h8A00);
        drive(16'h5555);
        checks++;
        if (wr_strobe !== 1'b0 || err_cnt !== 8'd2 || txd_data !== 16'h5555 ||
            reg_q !== m_q()) begin
            failures++;
            $display("FAIL unm_wr strb=%b err=%0d txd=%h", wr_strobe, err_cnt, txd_data);
        end
    endtask

    task automatic test_abort();
        logic [7:0] e0;
        e0 = err_cnt;
        cs_n_i = 1'b1; idle(2); cs_n_i = 1'b0; idle(2);
        checks++;
        if (err_cnt !== e0) begin
            failures++; $display("FAIL cs_idle err=%0d exp=%0d", err_cnt, e0);
        end
        drive(16'h8100);
        idle(2);
        cs_n_i = 1'b1;
        idle(1);
        m_abort();
        cs_n_i = 1'b0;
        checks++;
        if (err_cnt !== 8'(m_err) || err_cnt !== e0 + 8'd1) begin
            failures++; $display("FAIL cs_abort err=%0d exp=%0d", err_cnt, m_err);
        end
        drive(16'h0100);
        checks++;
        if (txd_data !== 16'h0000 || reg_q[31:16] !== 16'h0000) begin
            failures++; $display("FAIL abort_r1 txd=%h exp=0000", txd_data);
        end
        // data word and CS rise in the same cycle: data wins
        drive(16'h8100);
        cs_n_i = 1'b1;
        drive(16'hC0DE);
        idle(1);
        cs_n_i = 1'b0;
        checks++;
        if (reg_q[31:16] !== 16'hC0DE || err_cnt !== 8'(m_err)) begin
            failures++;
            $display("FAIL cs_race r1=%h err=%0d exp=c0de/%0d", reg_q[31:16], err_cnt, m_err);
        end
    endtask

    task automatic test_timeout();
        drive(16'h8100);
        idle(TO);
        m_abort();
        checks++;
        if (err_cnt !== 8'(m_err)) begin
            failures++; $display("FAIL timeout err=%0d exp=%0d", err_cnt, m_err);
        end
        drive(16'h0100);
        checks++;
        if (txd_data !== 16'hC0DE) begin
            failures++; $display("FAIL to_idle txd=%h exp=c0de", txd_data);
        end
        // data word arriving in the expiry cycle is accepted
        drive(16'h8100);
        idle(TO - 1);
        drive(16'h5A5A);
        checks++;
        if (wr_strobe !== 1'b1 || reg_q[31:16] !== 16'h5A5A || err_cnt !== 8'(m_err)) begin
            failures++;
            $display("FAIL to_race strb=%b r1=%h err=%0d", wr_strobe, reg_q[31:16], err_cnt);
        end
    endtask

    task automatic test_status();
        drive(16'h7F00);
        checks++;
        if (txd_data !== m_txd || err_cnt !== 8'(m_err)) begin
            failures++;
            $display("FAIL status txd=%h err=%0d exp=%h/%0d", txd_data, err_cnt, m_txd, m_err);
        end
    endtask

    task automatic test_reset_mid();
        drive(16'h8300);
        idle(1);
        rst_n = 1'b0;
        #1;
        m_reset();
        checks++;
        if (txd_data !== 16'h0 || err_cnt !== 8'h0 || reg_q !== '0 || wr_strobe !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid txd=%h err=%0d q=%h", txd_data, err_cnt, reg_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        drive(16'h00FF);
        checks++;
        if (txd_data !== 16'h0 || reg_q !== '0 || wr_strobe !== 1'b0 || err_cnt !== 8'h0) begin
            failures++;
            $display("FAIL rst_then_rd txd=%h q=%h strb=%b", txd_data, reg_q, wr_strobe);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int a;
        for (int i = 0; i < 300; i++) begin
            w = 16'($urandom);
            a = $urandom_range(0, 9);
            if ($urandom_range(0, 9) == 0) a = 127;
            if (!m_pend) w[14:8] = 7'(a);
            drive(w);
            checks++;
            if (txd_data !== m_txd || err_cnt !== 8'(m_err) || wr_strobe !== m_strb ||
                (m_strb && wr_addr !== 7'(m_waddr)) || reg_q !== m_q()) begin
                failures++;
                $display("FAIL rand[%0d] w=%h txd=%h/%h err=%0d/%0d strb=%b/%b",
                         i, w, txd_data, m_txd, err_cnt, m_err, wr_strobe, m_strb);
            end
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_saturate();
        if (m_pend) drive(16'h0000);
        for (int i = 0; i < 270; i++) drive(16'h0A00);
        checks++;
        if (err_cnt !== 8'hFF || err_cnt !== 8'(m_err)) begin
            failures++; $display("FAIL saturate err=%0d exp=255", err_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_unmapped();
        test_abort();
        test_timeout();
        test_status();
        test_reset_mid();
        test_back_to_back();
        test_status();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
